// File: rtl/run_ctrl.sv
// Debug run-control sequencer: takes host commands and gates the core clock-enable
// for single step, counted run or free run, stopping on halt, breakpoint or host stop.
module run_ctrl #(
  parameter int CNT_W = 32,
  parameter bit BP_EN = 1'b1
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             CMD_VALID,
  output logic             CMD_READY,
  input  logic [1:0]       CMD_OP,
  input  logic [CNT_W-1:0] CMD_ARG,
  input  logic             STOP_REQ,
  input  logic             HALT_IN,
  input  logic             BP_HIT,
  output logic             CPU_CE,
  output logic             BUSY,
  output logic             DONE,
  output logic [2:0]       STOP_CAUSE,
  output logic [CNT_W-1:0] REMAIN,
  output logic [CNT_W-1:0] CYC_CNT
);

  localparam logic [1:0] OP_CLR  = 2'd0;
  localparam logic [1:0] OP_STEP = 2'd1;
  localparam logic [1:0] OP_RUNN = 2'd2;
  localparam logic [1:0] OP_RUN  = 2'd3;

  localparam logic [2:0] C_NONE = 3'd0;
  localparam logic [2:0] C_STEP = 3'd1;
  localparam logic [2:0] C_CNT  = 3'd2;
  localparam logic [2:0] C_HOST = 3'd3;
  localparam logic [2:0] C_HALT = 3'd4;
  localparam logic [2:0] C_BP   = 3'd5;

  localparam logic [CNT_W-1:0] CNT_ZERO = '0;
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_STEP = 3'd1,
    S_RUNN = 3'd2,
    S_RUNF = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t state, state_nxt;

  logic             accept;
  logic             bp_act;
  logic             stop_now;
  logic             run_st;
  logic [2:0]       cause_q;
  logic [CNT_W-1:0] remain_q;
  logic [CNT_W-1:0] cyc_q;

  // Any active stop source wins over step/count completion; halt outranks breakpoint.
  function automatic logic [2:0] stop_code(input logic halt, input logic bp);
    if (halt)
      return C_HALT;
    else if (bp)
      return C_BP;
    else
      return C_HOST;
  endfunction

  assign bp_act   = BP_EN & BP_HIT;
  assign stop_now = HALT_IN | bp_act | STOP_REQ;
  assign run_st   = (state == S_STEP) || (state == S_RUNN) || (state == S_RUNF);
  assign accept   = CMD_VALID & CMD_READY;

  always_ff @(posedge CLK) begin
    if (RST)
      state <= S_IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (accept) begin
          case (CMD_OP)
            OP_STEP: state_nxt = S_STEP;
            OP_RUNN: state_nxt = (CMD_ARG == CNT_ZERO) ? S_DONE : S_RUNN;
            OP_RUN:  state_nxt = S_RUNF;
            default: state_nxt = S_IDLE;
          endcase
        end
      end
      S_STEP: state_nxt = S_DONE;
      S_RUNN: if (stop_now || (remain_q == CNT_ONE)) state_nxt = S_DONE;
      S_RUNF: if (stop_now) state_nxt = S_DONE;
      S_DONE: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    CMD_READY = (state == S_IDLE);
    BUSY      = run_st;
    DONE      = (state == S_DONE);
    CPU_CE    = run_st & ~stop_now & ~RST;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      cause_q  <= C_NONE;
      remain_q <= CNT_ZERO;
      cyc_q    <= CNT_ZERO;
    end else begin
      if (CPU_CE)
        cyc_q <= cyc_q + CNT_ONE;
      if (accept) begin
        cause_q <= C_NONE;
        case (CMD_OP)
          OP_CLR: begin
            cyc_q    <= CNT_ZERO;
            remain_q <= CNT_ZERO;
          end
          OP_RUNN: begin
            remain_q <= CMD_ARG;
            if (CMD_ARG == CNT_ZERO)
              cause_q <= C_CNT;
          end
          default: ;
        endcase
      end else if (run_st) begin
        if (stop_now)
          cause_q <= stop_code(HALT_IN, bp_act);
        else if (state == S_STEP)
          cause_q <= C_STEP;
        else if (state == S_RUNN) begin
          remain_q <= remain_q - CNT_ONE;
          if (remain_q == CNT_ONE)
            cause_q <= C_CNT;
        end
      end
    end
  end

  assign STOP_CAUSE = cause_q;
  assign REMAIN     = remain_q;
  assign CYC_CNT    = cyc_q;

endmodule

// File: tb/tb_run_ctrl.sv
// Bench for run_ctrl: two instances (32-bit with breakpoints, 8-bit without) share
// stimulus; expected results come from a per-command outcome model.
module tb_run_ctrl;

  localparam logic [1:0] OP_CLR  = 2'd0;
  localparam logic [1:0] OP_STEP = 2'd1;
  localparam logic [1:0] OP_RUNN = 2'd2;
  localparam logic [1:0] OP_RUN  = 2'd3;

  localparam logic [2:0] K_HALT = 3'b100;
  localparam logic [2:0] K_BP   = 3'b010;
  localparam logic [2:0] K_STOP = 3'b001;

  logic        CLK = 1'b0;
  logic        RST;
  logic        CMD_VALID;
  logic [1:0]  CMD_OP;
  logic [31:0] CMD_ARG;
  logic        STOP_REQ, HALT_IN, BP_HIT;

  logic        rdy[2], ce[2], busy[2], done[2];
  logic [2:0]  cause[2];
  logic [31:0] rem_a, cyc_a;
  logic [7:0]  rem_b, cyc_b;

  always #5 CLK = ~CLK;

  run_ctrl #(.CNT_W(32), .BP_EN(1'b1)) dut_a (
    .CLK(CLK), .RST(RST), .CMD_VALID(CMD_VALID), .CMD_READY(rdy[0]),
    .CMD_OP(CMD_OP), .CMD_ARG(CMD_ARG), .STOP_REQ(STOP_REQ), .HALT_IN(HALT_IN),
    .BP_HIT(BP_HIT), .CPU_CE(ce[0]), .BUSY(busy[0]), .DONE(done[0]),
    .STOP_CAUSE(cause[0]), .REMAIN(rem_a), .CYC_CNT(cyc_a)
  );

  run_ctrl #(.CNT_W(8), .BP_EN(1'b0)) dut_b (
    .CLK(CLK), .RST(RST), .CMD_VALID(CMD_VALID), .CMD_READY(rdy[1]),
    .CMD_OP(CMD_OP), .CMD_ARG(CMD_ARG[7:0]), .STOP_REQ(STOP_REQ), .HALT_IN(HALT_IN),
    .BP_HIT(BP_HIT), .CPU_CE(ce[1]), .BUSY(busy[1]), .DONE(done[1]),
    .STOP_CAUSE(cause[1]), .REMAIN(rem_b), .CYC_CNT(cyc_b)
  );

  int n_vec = 0;
  int n_err = 0;

  bit          bp_en[2] = '{1'b1, 1'b0};
  logic [31:0] mask[2]  = '{32'hFFFF_FFFF, 32'h0000_00FF};
  logic [31:0] rem_m[2];
  logic [31:0] cyc_m[2];
  logic [2:0]  cause_m[2];
  bit          chained = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] rem_o(input int i);
    return (i == 0) ? rem_a : {24'b0, rem_b};
  endfunction

  function automatic logic [31:0] cyc_o(input int i);
    return (i == 0) ? cyc_a : {24'b0, cyc_b};
  endfunction

  task automatic chk_final(input int i, input string sfx);
    chk($sformatf("%0d.cause%s", i, sfx), 32'(cause[i]), 32'(cause_m[i]));
    chk($sformatf("%0d.remain%s", i, sfx), rem_o(i), rem_m[i]);
    chk($sformatf("%0d.cyc%s", i, sfx), cyc_o(i), cyc_m[i]);
  endtask

  // s: run cycle (1 = first cycle after accept) in which the stop sources in 'kind'
  // are asserted for one cycle (s==1 also asserts them in the accept cycle); 0 = none.
  task automatic do_cmd(input logic [1:0] op, input logic [31:0] arg, input int s,
                        input logic [2:0] kind, input bit hold);
    int  ce_e[2];
    int  d_e[2];
    int  maxd;
    int  len;
    bit  eff;
    for (int i = 0; i < 2; i++) begin
      eff = (s > 0) && (kind[2] || kind[0] || (kind[1] && bp_en[i]));
      if (op == OP_CLR) begin
        ce_e[i] = 0; d_e[i] = 0;
        cause_m[i] = 3'd0; rem_m[i] = 32'd0; cyc_m[i] = 32'd0;
      end else begin
        len = (op == OP_STEP) ? 1 : (op == OP_RUNN) ? int'(arg) : 1 << 30;
        if (eff && s <= len) begin
          ce_e[i] = s - 1;
          d_e[i]  = s + 1;
          cause_m[i] = kind[2] ? 3'd4 : (kind[1] && bp_en[i]) ? 3'd5 : 3'd3;
          if (op == OP_RUNN) rem_m[i] = arg - 32'(s - 1);
        end else begin
          ce_e[i] = len;
          d_e[i]  = len + 1;
          cause_m[i] = (op == OP_STEP) ? 3'd1 : 3'd2;
          if (op == OP_RUNN) rem_m[i] = 32'd0;
        end
        cyc_m[i] = (cyc_m[i] + 32'(ce_e[i])) & mask[i];
      end
    end
    maxd = (d_e[0] > d_e[1]) ? d_e[0] : d_e[1];

    if (!chained) @(negedge CLK);
    CMD_VALID = 1'b1;
    CMD_OP    = op;
    CMD_ARG   = arg;
    {HALT_IN, BP_HIT, STOP_REQ} = (s == 1) ? kind : 3'b000;
    #1;
    for (int i = 0; i < 2; i++) chk($sformatf("%0d.rdy_acc", i), 32'(rdy[i]), 32'd1);

    for (int j = 1; j <= maxd + 1; j++) begin
      @(negedge CLK);
      CMD_VALID = hold;
      {HALT_IN, BP_HIT, STOP_REQ} = (j == s) ? kind : 3'b000;
      #1;
      for (int i = 0; i < 2; i++) begin
        chk($sformatf("%0d.ce@%0d", i, j), 32'(ce[i]), 32'(j <= ce_e[i]));
        chk($sformatf("%0d.busy@%0d", i, j), 32'(busy[i]), 32'(j < d_e[i]));
        chk($sformatf("%0d.done@%0d", i, j), 32'(done[i]), 32'(j == d_e[i]));
        chk($sformatf("%0d.rdy@%0d", i, j), 32'(rdy[i]), 32'(j > d_e[i]));
        if (j == maxd + 1) chk_final(i, "");
      end
    end
    {HALT_IN, BP_HIT, STOP_REQ} = 3'b000;
    chained = hold;
  endtask

  task automatic run_then_reset(input int k);
    @(negedge CLK);
    CMD_VALID = 1'b1; CMD_OP = OP_RUN; CMD_ARG = 32'd0;
    {HALT_IN, BP_HIT, STOP_REQ} = 3'b000;
    for (int j = 1; j <= k; j++) begin
      @(negedge CLK);
      CMD_VALID = 1'b0;
      #1;
      for (int i = 0; i < 2; i++) chk($sformatf("%0d.rst_run_ce", i), 32'(ce[i]), 32'd1);
    end
    @(negedge CLK);
    RST = 1'b1;
    #1;
    for (int i = 0; i < 2; i++) chk($sformatf("%0d.rst_ce", i), 32'(ce[i]), 32'd0);
    @(negedge CLK);
    RST = 1'b0;
    for (int i = 0; i < 2; i++) begin
      cause_m[i] = 3'd0; rem_m[i] = 32'd0; cyc_m[i] = 32'd0;
    end
    #1;
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("%0d.post_rst_ce", i), 32'(ce[i]), 32'd0);
      chk($sformatf("%0d.post_rst_busy", i), 32'(busy[i]), 32'd0);
      chk($sformatf("%0d.post_rst_done", i), 32'(done[i]), 32'd0);
      chk($sformatf("%0d.post_rst_rdy", i), 32'(rdy[i]), 32'd1);
      chk_final(i, "_rst");
    end
    chained = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [1:0]  op;
    logic [31:0] arg;
    int          s;
    logic [2:0]  kind;

    RST = 1'b1; CMD_VALID = 1'b0; CMD_OP = 2'd0; CMD_ARG = 32'd0;
    STOP_REQ = 1'b0; HALT_IN = 1'b0; BP_HIT = 1'b0;
    for (int i = 0; i < 2; i++) begin
      cause_m[i] = 3'd0; rem_m[i] = 32'd0; cyc_m[i] = 32'd0;
    end
    repeat (3) @(negedge CLK);
    #1;
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("%0d.reset_ce", i), 32'(ce[i]), 32'd0);
      chk($sformatf("%0d.reset_busy", i), 32'(busy[i]), 32'd0);
      chk($sformatf("%0d.reset_done", i), 32'(done[i]), 32'd0);
      chk($sformatf("%0d.reset_rdy", i), 32'(rdy[i]), 32'd1);
      chk_final(i, "_reset");
    end
    RST = 1'b0;

    do_cmd(OP_RUNN, 32'd5, 0, 3'b000, 1'b0);
    do_cmd(OP_STEP, 32'd0, 0, 3'b000, 1'b1);
    do_cmd(OP_STEP, 32'd0, 0, 3'b000, 1'b1);
    do_cmd(OP_STEP, 32'd0, 0, 3'b000, 1'b0);
    do_cmd(OP_CLR,  32'd0, 0, 3'b000, 1'b0);
    do_cmd(OP_RUN,  32'd0, 11, K_STOP, 1'b0);
    do_cmd(OP_RUN,  32'd0, 11, K_HALT | K_BP | K_STOP, 1'b0);
    do_cmd(OP_RUN,  32'd0, 4, K_BP | K_STOP, 1'b0);
    do_cmd(OP_RUNN, 32'd0, 0, 3'b000, 1'b0);
    do_cmd(OP_RUNN, 32'd100, 41, K_BP, 1'b0);
    do_cmd(OP_RUNN, 32'd7, 1, K_HALT, 1'b0);
    do_cmd(OP_STEP, 32'd0, 1, K_STOP, 1'b0);
    do_cmd(OP_RUNN, 32'd3, 3, K_STOP, 1'b0);
    run_then_reset(6);
    do_cmd(OP_RUNN, 32'd4, 0, 3'b000, 1'b0);
    do_cmd(OP_CLR,  32'd0, 0, 3'b000, 1'b0);
    do_cmd(OP_RUNN, 32'd255, 0, 3'b000, 1'b0);
    do_cmd(OP_RUNN, 32'd2, 0, 3'b000, 1'b0);

    for (int n = 0; n < 80; n++) begin
      op   = 2'($urandom_range(0, 3));
      arg  = ($urandom_range(0, 7) == 0) ? 32'd0 : 32'($urandom_range(1, 40));
      s    = int'($urandom_range(0, 15));
      kind = 3'($urandom_range(0, 7));
      if (op == OP_RUN) begin
        if (s == 0) s = int'($urandom_range(1, 15));
        if (!kind[2] && !kind[0]) kind[0] = 1'b1;
      end
      do_cmd(op, arg, s, kind, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
